// File: rtl/chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
//
// Multi-cycle adder. It latches two WIDTH-bit operands and a carry-in. It then
// adds them CHUNK bits per clock, rippling the carry between chunks through a
// stored carry flop. After N = WIDTH/CHUNK RUN cycles it presents the sum, the
// unsigned carry-out and the two's-complement overflow. The result is held
// until the consumer takes it.
//
// Optional feature: when the macro CHUNK_ADDER_SUB_EN is defined, the block has
// an extra input port `sub`, which is latched at accept. With sub=1 the block
// computes x + ~y + 1 and ignores cin. cout=1 then means "no borrow".
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands/cin presented
//   in_ready   out  block idle and able to accept operands
//   x, y       in   WIDTH-bit operands
//   cin        in   carry-in
//   sub        in   (CHUNK_ADDER_SUB_EN only) subtract select
//   out_valid  out  result valid and held stable
//   out_ready  in   consumer takes result
//   s          out  WIDTH-bit sum
//   cout       out  carry out of bit WIDTH-1
//   ovf        out  two's-complement overflow
// -----------------------------------------------------------------------------
module chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
`ifdef CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;

    logic [WIDTH-1:0]  y_acc_s;
    logic              cin_acc_s;
    logic [CHUNK-1:0]  x_chunk_s;
    logic [CHUNK-1:0]  y_chunk_s;
    logic [CHUNK:0]    chunk_sum_s;

    // Operand conditioning at accept: subtraction is folded into the stored
    // operand (~y) and stored carry (1), so the RUN datapath only ever adds.
    always_comb begin
        y_acc_s   = y;
        cin_acc_s = cin;
`ifdef CHUNK_ADDER_SUB_EN
        if (sub) begin
            y_acc_s   = ~y;
            cin_acc_s = 1'b1;
        end else begin
            y_acc_s   = y;
            cin_acc_s = cin;
        end
`endif
    end

    // One chunk of the ripple: chunk k of both operands plus the stored carry.
    always_comb begin
        x_chunk_s   = x_q[k_q*CHUNK +: CHUNK];
        y_chunk_s   = y_q[k_q*CHUNK +: CHUNK];
        chunk_sum_s = {1'b0, x_chunk_s} + {1'b0, y_chunk_s} + {{CHUNK{1'b0}}, carry_q};
    end

    // Next-state and datapath update logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        carry_d     = carry_q;
        x_d         = x_q;
        y_d         = y_q;
        s_d         = s_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    y_d     = y_acc_s;
                    carry_d = cin_acc_s;
                    k_d     = {KW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_d[k_q*CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
                carry_d                 = chunk_sum_s[CHUNK];
                if (k_q == K_LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    cout_d      = chunk_sum_s[CHUNK];
                    // The carry into the MSB is recovered from the MSB's sum
                    // bit and operand bits. Overflow is that carry XOR the
                    // carry out of the MSB.
                    ovf_d       = x_q[WIDTH-1] ^ y_q[WIDTH-1]
                                ^ chunk_sum_s[CHUNK-1] ^ chunk_sum_s[CHUNK];
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= {KW{1'b0}};
            carry_q     <= 1'b0;
            x_q         <= {WIDTH{1'b0}};
            y_q         <= {WIDTH{1'b0}};
            s_q         <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            x_q         <= x_d;
            y_q         <= y_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunk_adder.sv
// -----------------------------------------------------------------------------
// tb_chunk_adder
//
// Self-checking bench for chunk_adder. It instantiates a 32/8 instance and an
// 8/8 instance. Expected results come from plain wide-integer arithmetic, and
// overflow comes from the operand/result sign rule. Directed corner cases are
// mixed with $urandom operands.
// -----------------------------------------------------------------------------
module tb_chunk_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] x, y, s;

    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  x8, y8, s8;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .cin(cin),
`ifdef CHUNK_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
    );

    chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .x(x8), .y(y8), .cin(cin8),
`ifdef CHUNK_ADDER_SUB_EN
        .sub(sub8),
`endif
        .out_valid(out_valid8), .out_ready(out_ready8), .s(s8), .cout(cout8), .ovf(ovf8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: {ovf, cout, s}. Subtraction is x + ~y + 1.
    function automatic logic [33:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic sb);
        logic [31:0] bb;
        logic        cc;
        logic [32:0] full;
        logic        v;
        bb   = sb ? ~b : b;
        cc   = sb ? 1'b1 : c;
        full = {1'b0, a} + {1'b0, bb} + {32'd0, cc};
        v    = (a[31] == bb[31]) && (full[31] != a[31]);
        return {v, full};
    endfunction

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic sb, input int hold, input string tag);
        logic [33:0] e;
        int          lat;
        e = ref32(a, b, c, sb);
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; x = a; y = b; cin = c; sub = sb;
        tick();
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            x = $urandom; y = $urandom;
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'd4);
        check({tag, " s"}, 64'(s), 64'(e[31:0]));
        check({tag, " cout"}, 64'(cout), 64'(e[32]));
        check({tag, " ovf"}, 64'(ovf), 64'(e[33]));
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, " hold s"}, 64'(s), 64'(e[31:0]));
            check({tag, " hold cout"}, 64'(cout), 64'(e[32]));
            check({tag, " hold ovf"}, 64'(ovf), 64'(e[33]));
            check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " release out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " release in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
        logic [8:0] full;
        logic       v;
        int         lat;
        full = {1'b0, a} + {1'b0, b} + {8'd0, c};
        v    = (a[7] == b[7]) && (full[7] != a[7]);
        for (int i = 0; i < 20 && !in_ready8; i++) tick();
        in_valid8 = 1'b1; x8 = a; y8 = b; cin8 = c;
        tick();
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            in_valid8 = 1'b0;
            x8 = 8'($urandom); y8 = 8'($urandom);
            tick();
            if (out_valid8) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'd1);
        check({tag, " s"}, 64'(s8), 64'(full[7:0]));
        check({tag, " cout"}, 64'(cout8), 64'(full[8]));
        check({tag, " ovf"}, 64'(ovf8), 64'(v));
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        check({tag, " release in_ready"}, 64'(in_ready8), 64'd1);
    endtask

    initial begin
        in_valid = 1'b0; x = 32'd0; y = 32'd0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        in_valid8 = 1'b0; x8 = 8'd0; y8 = 8'd0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        check("reset s", 64'(s), 64'd0);
        check("reset cout", 64'(cout), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        run32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0, "carry_all");
        run32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "pos_ovf");
        run32(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 0, "chunk_carry");
        run32(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0, "neg_ovf");
        run32($urandom, $urandom, 1'b1, 1'b0, 10, "hold");

        // Abort an operation part-way through with an asynchronous reset.
        in_valid = 1'b1; x = 32'hAAAA_AAAA; y = 32'h5555_5555; cin = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort s", 64'(s), 64'd0);
        check("abort cout", 64'(cout), 64'd0);
        check("abort ovf", 64'(ovf), 64'd0);
        check("abort out_valid", 64'(out_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort in_ready", 64'(in_ready), 64'd1);
        run32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0, "post_reset");

`ifdef CHUNK_ADDER_SUB_EN
        run32(32'd5, 32'd7, 1'b0, 1'b1, 0, "sub_borrow");
        run32(32'h8000_0000, 32'd1, 1'b1, 1'b1, 0, "sub_ovf");
        for (int r = 0; r < 8; r++)
            run32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 0, "sub_rand");
`endif

        for (int r = 0; r < 16; r++)
            run32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, r % 3, "rand");

        run8(8'hC8, 8'h64, 1'b0, "w8");
        for (int r = 0; r < 8; r++)
            run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "w8_rand");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
